// File: rtl/dual_port_regfile.sv
// Architectural 32x32 integer register file fed by the dual-issue writeback bus.
// Four combinational read ports with optional write-through bypass, plus a registered commit trace.
module dual_port_regfile #(
  parameter bit BYPASS_EN = 1'b1,
  parameter int CNT_WD    = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [139:0]      ws_to_rf_bus,
  input  logic [4:0]        raddr1_a,
  input  logic [4:0]        raddr1_b,
  input  logic [4:0]        raddr2_a,
  input  logic [4:0]        raddr2_b,
  output logic [31:0]       rdata1_a,
  output logic [31:0]       rdata1_b,
  output logic [31:0]       rdata2_a,
  output logic [31:0]       rdata2_b,
  output logic [1:0]        dbg_we,
  output logic [31:0]       dbg_pc1,
  output logic [31:0]       dbg_pc2,
  output logic [4:0]        dbg_wnum1,
  output logic [4:0]        dbg_wnum2,
  output logic [31:0]       dbg_wdata1,
  output logic [31:0]       dbg_wdata2,
  output logic [CNT_WD-1:0] wr_count
);

  // Interface contract: there is no valid/ready pair. The bus is consumed on every
  // rising edge and this block never stalls; an idle slot simply has its we bit low.
  logic [31:0] pc1, pc2, wdata1, wdata2;
  logic        we1, we2;
  logic [4:0]  waddr1, waddr2;
  logic        ew1, ew2;

  assign pc1    = ws_to_rf_bus[139:108];
  assign we1    = ws_to_rf_bus[107];
  assign waddr1 = ws_to_rf_bus[106:102];
  assign wdata1 = ws_to_rf_bus[101:70];
  assign pc2    = ws_to_rf_bus[69:38];
  assign we2    = ws_to_rf_bus[37];
  assign waddr2 = ws_to_rf_bus[36:32];
  assign wdata2 = ws_to_rf_bus[31:0];

  // Slot 2 is younger, so it owns a same-address collision even if upstream forgot to mask.
  assign ew2 = we2 && (waddr2 != 5'd0);
  assign ew1 = we1 && (waddr1 != 5'd0) && !(we2 && (waddr2 == waddr1));

  logic [31:0] regs [1:31];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < 32; i++) regs[i] <= '0;
    end else begin
      if (ew1) regs[waddr1] <= wdata1;
      if (ew2) regs[waddr2] <= wdata2;
    end
  end

  logic [4:0]  raddr [4];
  logic [31:0] rdata [4];

  assign raddr[0] = raddr1_a;
  assign raddr[1] = raddr1_b;
  assign raddr[2] = raddr2_a;
  assign raddr[3] = raddr2_b;

  // ewN already implies a nonzero address, so bypass can never make r0 nonzero.
  always_comb begin
    for (int p = 0; p < 4; p++) begin
      rdata[p] = '0;
      for (int i = 1; i < 32; i++) begin
        if (raddr[p] == 5'(i)) rdata[p] = regs[i];
      end
      if (BYPASS_EN) begin
        if (ew2 && (raddr[p] == waddr2))      rdata[p] = wdata2;
        else if (ew1 && (raddr[p] == waddr1)) rdata[p] = wdata1;
      end
    end
  end

  assign rdata1_a = rdata[0];
  assign rdata1_b = rdata[1];
  assign rdata2_a = rdata[2];
  assign rdata2_b = rdata[3];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dbg_we     <= '0;
      dbg_pc1    <= '0;
      dbg_pc2    <= '0;
      dbg_wnum1  <= '0;
      dbg_wnum2  <= '0;
      dbg_wdata1 <= '0;
      dbg_wdata2 <= '0;
      wr_count   <= '0;
    end else begin
      dbg_we     <= {ew2, ew1};
      dbg_pc1    <= pc1;
      dbg_pc2    <= pc2;
      dbg_wnum1  <= waddr1;
      dbg_wnum2  <= waddr2;
      dbg_wdata1 <= wdata1;
      dbg_wdata2 <= wdata2;
      wr_count   <= wr_count + CNT_WD'(ew1) + CNT_WD'(ew2);
    end
  end

endmodule

// File: tb/tb_dual_port_regfile.sv
// Directed bench for dual_port_regfile: a bypassing and a non-bypassing instance share one bus.
// Driver pushes expected values into a queue; a negedge monitor pops and compares.
module tb_dual_port_regfile;

  localparam int W = 68;  // {sel[3:0], value[63:0]}

  localparam logic [3:0] S_RD0 = 4'd0, S_RD1 = 4'd1, S_RD2 = 4'd2, S_RD3 = 4'd3;
  localparam logic [3:0] S_NB0 = 4'd4, S_NB1 = 4'd5, S_NB2 = 4'd6, S_NB3 = 4'd7;
  localparam logic [3:0] S_WE = 4'd8, S_WN1 = 4'd9, S_WN2 = 4'd10, S_WD1 = 4'd11;
  localparam logic [3:0] S_WD2 = 4'd12, S_PC1 = 4'd13, S_PC2 = 4'd14, S_CNT = 4'd15;

  logic         clk;
  logic         reset;
  logic [139:0] ws_to_rf_bus;
  logic [4:0]   raddr1_a, raddr1_b, raddr2_a, raddr2_b;
  logic [31:0]  rdata1_a, rdata1_b, rdata2_a, rdata2_b;
  logic [31:0]  nb_rdata1_a, nb_rdata1_b, nb_rdata2_a, nb_rdata2_b;
  logic [1:0]   dbg_we, nb_dbg_we;
  logic [31:0]  dbg_pc1, dbg_pc2, nb_dbg_pc1, nb_dbg_pc2;
  logic [4:0]   dbg_wnum1, dbg_wnum2, nb_dbg_wnum1, nb_dbg_wnum2;
  logic [31:0]  dbg_wdata1, dbg_wdata2, nb_dbg_wdata1, nb_dbg_wdata2;
  logic [63:0]  wr_count, nb_wr_count;

  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;

  dual_port_regfile #(.BYPASS_EN(1'b1), .CNT_WD(64)) dut (
    .clk(clk), .reset(reset), .ws_to_rf_bus(ws_to_rf_bus),
    .raddr1_a(raddr1_a), .raddr1_b(raddr1_b), .raddr2_a(raddr2_a), .raddr2_b(raddr2_b),
    .rdata1_a(rdata1_a), .rdata1_b(rdata1_b), .rdata2_a(rdata2_a), .rdata2_b(rdata2_b),
    .dbg_we(dbg_we), .dbg_pc1(dbg_pc1), .dbg_pc2(dbg_pc2),
    .dbg_wnum1(dbg_wnum1), .dbg_wnum2(dbg_wnum2),
    .dbg_wdata1(dbg_wdata1), .dbg_wdata2(dbg_wdata2), .wr_count(wr_count)
  );

  dual_port_regfile #(.BYPASS_EN(1'b0), .CNT_WD(64)) dut_nb (
    .clk(clk), .reset(reset), .ws_to_rf_bus(ws_to_rf_bus),
    .raddr1_a(raddr1_a), .raddr1_b(raddr1_b), .raddr2_a(raddr2_a), .raddr2_b(raddr2_b),
    .rdata1_a(nb_rdata1_a), .rdata1_b(nb_rdata1_b), .rdata2_a(nb_rdata2_a), .rdata2_b(nb_rdata2_b),
    .dbg_we(nb_dbg_we), .dbg_pc1(nb_dbg_pc1), .dbg_pc2(nb_dbg_pc2),
    .dbg_wnum1(nb_dbg_wnum1), .dbg_wnum2(nb_dbg_wnum2),
    .dbg_wdata1(nb_dbg_wdata1), .dbg_wdata2(nb_dbg_wdata2), .wr_count(nb_wr_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic drive_bus(input logic we1, input logic [4:0] wa1, input logic [31:0] wd1,
                           input logic [31:0] pc1, input logic we2, input logic [4:0] wa2,
                           input logic [31:0] wd2, input logic [31:0] pc2);
    ws_to_rf_bus = {pc1, we1, wa1, wd1, pc2, we2, wa2, wd2};
  endtask

  task automatic idle_bus();
    drive_bus(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0);
  endtask

  task automatic set_raddr(input logic [4:0] a, input logic [4:0] b,
                           input logic [4:0] c, input logic [4:0] d);
    raddr1_a = a; raddr1_b = b; raddr2_a = c; raddr2_b = d;
  endtask

  // Advance to just after the next rising edge; inputs change here, checks happen at negedge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input logic [3:0] sel, input logic [63:0] val);
    exp_q.push_back({sel, val});
  endtask

  // ---------------- scoreboard monitor ----------------
  function automatic logic [63:0] actual_of(input logic [3:0] sel);
    case (sel)
      S_RD0: return 64'(rdata1_a);
      S_RD1: return 64'(rdata1_b);
      S_RD2: return 64'(rdata2_a);
      S_RD3: return 64'(rdata2_b);
      S_NB0: return 64'(nb_rdata1_a);
      S_NB1: return 64'(nb_rdata1_b);
      S_NB2: return 64'(nb_rdata2_a);
      S_NB3: return 64'(nb_rdata2_b);
      S_WE:  return 64'(dbg_we);
      S_WN1: return 64'(dbg_wnum1);
      S_WN2: return 64'(dbg_wnum2);
      S_WD1: return 64'(dbg_wdata1);
      S_WD2: return 64'(dbg_wdata2);
      S_PC1: return 64'(dbg_pc1);
      S_PC2: return 64'(dbg_pc2);
      default: return wr_count;
    endcase
  endfunction

  function automatic string name_of(input logic [3:0] sel);
    case (sel)
      S_RD0: return "rdata1_a";
      S_RD1: return "rdata1_b";
      S_RD2: return "rdata2_a";
      S_RD3: return "rdata2_b";
      S_NB0: return "nb_rdata1_a";
      S_NB1: return "nb_rdata1_b";
      S_NB2: return "nb_rdata2_a";
      S_NB3: return "nb_rdata2_b";
      S_WE:  return "dbg_we";
      S_WN1: return "dbg_wnum1";
      S_WN2: return "dbg_wnum2";
      S_WD1: return "dbg_wdata1";
      S_WD2: return "dbg_wdata2";
      S_PC1: return "dbg_pc1";
      S_PC2: return "dbg_pc2";
      default: return "wr_count";
    endcase
  endfunction

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [W-1:0] e;
      logic [63:0]  act;
      e   = exp_q.pop_front();
      act = actual_of(e[67:64]);
      n_checks++;
      if (act !== e[63:0]) begin
        n_fail++;
        $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name_of(e[67:64]), $time, act, e[63:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] cnt;
    reset = 1'b1;
    idle_bus();
    set_raddr(5'd5, 5'd7, 5'd3, 5'd0);
    #1 reset = 1'b0;

    // reset state
    next_cycle();
    for (int s = 0; s < 8; s++) expect_val(4'(s), 64'd0);
    expect_val(S_WE, 64'd0);
    expect_val(S_CNT, 64'd0);
    next_cycle();
    reset = 1'b1;

    // single write to r5: bypass on dut, stored value (still 0) on dut_nb
    next_cycle();
    drive_bus(1'b1, 5'd5, 32'h1234_5678, 32'h1C00_0000, 1'b0, 5'd0, 32'd0, 32'd0);
    set_raddr(5'd5, 5'd0, 5'd0, 5'd0);
    expect_val(S_RD0, 64'h1234_5678);
    expect_val(S_NB0, 64'd0);
    next_cycle();
    idle_bus();
    expect_val(S_RD0, 64'h1234_5678);
    expect_val(S_NB0, 64'h1234_5678);
    expect_val(S_WE,  64'h1);
    expect_val(S_WN1, 64'd5);
    expect_val(S_PC1, 64'h1C00_0000);
    expect_val(S_WD1, 64'h1234_5678);
    expect_val(S_CNT, 64'd1);

    // same-address collision on r7: slot 2 wins
    next_cycle();
    drive_bus(1'b1, 5'd7, 32'hAAAA_AAAA, 32'h100, 1'b1, 5'd7, 32'h5555_5555, 32'h104);
    set_raddr(5'd7, 5'd7, 5'd7, 5'd7);
    for (int s = 0; s < 4; s++) expect_val(4'(s), 64'h5555_5555);
    next_cycle();
    idle_bus();
    for (int s = 0; s < 8; s++) expect_val(4'(s), 64'h5555_5555);
    expect_val(S_WE,  64'h2);
    expect_val(S_WN2, 64'd7);
    expect_val(S_WD2, 64'h5555_5555);
    expect_val(S_PC2, 64'h104);
    expect_val(S_CNT, 64'd2);

    // write to r0 discarded, r3 = 9
    next_cycle();
    drive_bus(1'b1, 5'd0, 32'hFFFF_FFFF, 32'h200, 1'b1, 5'd3, 32'd9, 32'h204);
    set_raddr(5'd0, 5'd3, 5'd0, 5'd3);
    expect_val(S_RD0, 64'd0);
    expect_val(S_RD1, 64'd9);
    expect_val(S_NB1, 64'd0);
    next_cycle();
    idle_bus();
    expect_val(S_RD0, 64'd0);
    expect_val(S_RD1, 64'd9);
    expect_val(S_NB0, 64'd0);
    expect_val(S_WE,  64'h2);
    expect_val(S_WN1, 64'd0);
    expect_val(S_WD1, 64'hFFFF_FFFF);
    expect_val(S_CNT, 64'd3);

    // two distinct writes in one cycle
    next_cycle();
    drive_bus(1'b1, 5'd10, 32'h10, 32'h300, 1'b1, 5'd11, 32'h11, 32'h304);
    set_raddr(5'd10, 5'd0, 5'd0, 5'd11);
    expect_val(S_RD0, 64'h10);
    expect_val(S_RD3, 64'h11);
    next_cycle();
    idle_bus();
    expect_val(S_RD0, 64'h10);
    expect_val(S_RD3, 64'h11);
    expect_val(S_WE,  64'h3);
    expect_val(S_CNT, 64'd5);

    // non-bypass instance returns the old r4 in the write cycle
    next_cycle();
    drive_bus(1'b1, 5'd4, 32'd1, 32'h400, 1'b0, 5'd0, 32'd0, 32'd0);
    set_raddr(5'd4, 5'd0, 5'd0, 5'd0);
    next_cycle();
    drive_bus(1'b1, 5'd4, 32'd2, 32'h404, 1'b0, 5'd0, 32'd0, 32'd0);
    expect_val(S_NB0, 64'd1);
    expect_val(S_RD0, 64'd2);
    next_cycle();
    idle_bus();
    expect_val(S_NB0, 64'd2);
    expect_val(S_RD0, 64'd2);
    expect_val(S_CNT, 64'd7);

    // fill r1..r31 with 0xDEADBEEF, two registers per cycle
    cnt = 64'd7;
    for (int i = 1; i < 32; i += 2) begin
      next_cycle();
      if (i + 1 < 32) begin
        drive_bus(1'b1, 5'(i), 32'hDEAD_BEEF, 32'h500, 1'b1, 5'(i + 1), 32'hDEAD_BEEF, 32'h504);
        cnt += 2;
      end else begin
        drive_bus(1'b1, 5'(i), 32'hDEAD_BEEF, 32'h500, 1'b0, 5'd0, 32'd0, 32'd0);
        cnt += 1;
      end
    end
    next_cycle();
    idle_bus();
    set_raddr(5'd1, 5'd17, 5'd30, 5'd31);
    for (int s = 0; s < 8; s++) expect_val(4'(s), 64'hDEAD_BEEF);
    expect_val(S_CNT, cnt);

    // asynchronous reset mid-cycle: everything reads 0 before the next edge
    next_cycle();
    #1 reset = 1'b0;
    for (int s = 0; s < 8; s++) expect_val(4'(s), 64'd0);
    expect_val(S_WE,  64'd0);
    expect_val(S_WN1, 64'd0);
    expect_val(S_WN2, 64'd0);
    expect_val(S_WD1, 64'd0);
    expect_val(S_WD2, 64'd0);
    expect_val(S_PC1, 64'd0);
    expect_val(S_PC2, 64'd0);
    expect_val(S_CNT, 64'd0);

    next_cycle();
    next_cycle();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
